// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared widths and FSM state encoding for mem_ctrl
package mem_ctrl_pkg;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 4;
  localparam int CNT_W  = 3;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    RESP
  } state_t;
endpackage

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - request/response front end for an asynchronous 16x4 SRAM
// Generates CS/WE strobes with programmable setup, pulse and hold widths.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_d,
  input  logic [DATA_W-1:0] mem_q,
  output logic              mem_cs_n,
  output logic              mem_we_n
);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               ready_en;
  logic               we_q;
  logic               accept;
  logic               sample;
  logic [DATA_W-1:0]  q_samp;

  // ready_en keeps req_ready low until the first edge after reset release
  assign req_ready = ready_en && (state == IDLE);
  assign mem_cs_n  = !((state == SETUP) || (state == PULSE) || (state == HOLD));
  assign mem_we_n  = !((state == PULSE) && we_q);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    sample    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          accept    = 1'b1;
          state_nxt = SETUP;
          cnt_nxt   = '0;
        end
      end
      SETUP: begin
        if (cnt == SETUP_LAST) begin
          state_nxt = PULSE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      PULSE: begin
        if (cnt == PULSE_LAST) begin
          cnt_nxt = '0;
          if (we_q) begin
            state_nxt = HOLD;
          end else begin
            state_nxt = RESP;
            sample    = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Read data is presented one edge after RESP so rsp_rdata only moves with rsp_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      ready_en  <= 1'b0;
      we_q      <= 1'b0;
      mem_a     <= '0;
      mem_d     <= '0;
      q_samp    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      ready_en  <= 1'b1;
      rsp_valid <= (state == RESP);
      if (accept) begin
        we_q  <= req_we;
        mem_a <= req_addr;
        mem_d <= req_wdata;
      end
      if (sample) begin
        q_samp <= mem_q;
      end
      if (state == RESP) begin
        rsp_rdata <= q_samp;
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - randomized scoreboard bench for mem_ctrl
module tb_mem_ctrl;
  localparam int S  = 1, P  = 2, H  = 1;
  localparam int S2 = 2, P2 = 3, H2 = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic       a_req_valid = 1'b0, a_req_we = 1'b0;
  logic [3:0] a_req_addr = 4'h0, a_req_wdata = 4'h0;
  logic       a_req_ready, a_rsp_valid, a_cs_n, a_we_n;
  logic [3:0] a_rsp_rdata, a_mem_a, a_mem_d, a_mem_q, a_idx;

  logic       b_req_valid = 1'b0, b_req_we = 1'b0;
  logic [3:0] b_req_addr = 4'h0, b_req_wdata = 4'h0;
  logic       b_req_ready, b_rsp_valid, b_cs_n, b_we_n;
  logic [3:0] b_rsp_rdata, b_mem_a, b_mem_d, b_mem_q, b_idx;

  mem_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_we(a_req_we), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .mem_a(a_mem_a), .mem_d(a_mem_d),
    .mem_q(a_mem_q), .mem_cs_n(a_cs_n), .mem_we_n(a_we_n)
  );

  mem_ctrl #(.SETUP_CYC(S2), .PULSE_CYC(P2), .HOLD_CYC(H2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(b_req_we), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .mem_a(b_mem_a), .mem_d(b_mem_d),
    .mem_q(b_mem_q), .mem_cs_n(b_cs_n), .mem_we_n(b_we_n)
  );

  function automatic logic [3:0] init_val(input int i);
    return 4'((i * 5) + 3);
  endfunction

  // SRAM pins A0..A3 form the array index with A0 as MSB; A0 is mem_a[3]
  logic [3:0] a_ram [16];
  logic [3:0] b_ram [16];
  assign a_idx   = {a_mem_a[3], a_mem_a[2], a_mem_a[1], a_mem_a[0]};
  assign b_idx   = {b_mem_a[3], b_mem_a[2], b_mem_a[1], b_mem_a[0]};
  assign a_mem_q = a_ram[a_idx];
  assign b_mem_q = b_ram[b_idx];

  initial begin
    for (int i = 0; i < 16; i++) begin
      a_ram[i] = init_val(i);
      b_ram[i] = init_val(i);
    end
    forever begin
      @(posedge clk);
      if (!a_cs_n && !a_we_n) a_ram[a_idx] <= a_mem_d;
      if (!b_cs_n && !b_we_n) b_ram[b_idx] <= b_mem_d;
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model of the default-parameter instance
  bit         m_started = 1'b0, m_active = 1'b0, m_we = 1'b0;
  int         m_age = 0;
  int         n_acc = 0;
  logic [3:0] m_addr = 4'h0, m_data = 4'h0;
  logic [3:0] e_a = 4'h0, e_d = 4'h0, e_rdata = 4'h0;
  logic [3:0] exp_mem [16];

  function automatic bit m_idle();
    return !m_active || (m_we ? (m_age >= S + P + H) : (m_age >= S + P + 1));
  endfunction

  initial begin
    bit acc;
    for (int i = 0; i < 16; i++) exp_mem[i] = init_val(i);
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_started = 1'b0;
        m_active  = 1'b0;
        m_age     = 0;
        e_a       = 4'h0;
        e_d       = 4'h0;
        e_rdata   = 4'h0;
      end else begin
        acc = m_started && m_idle() && a_req_valid;
        if (m_active) begin
          m_age++;
          if (m_we && m_age == S + P + H) exp_mem[m_addr] = m_data;
          if (!m_we && m_age == S + P + 1) e_rdata = exp_mem[m_addr];
        end
        if (acc) begin
          n_acc++;
          m_active = 1'b1;
          m_age    = 0;
          m_we     = a_req_we;
          m_addr   = a_req_addr;
          m_data   = a_req_wdata;
          e_a      = a_req_addr;
          e_d      = a_req_wdata;
        end
        m_started = 1'b1;
      end
    end
  end

  // Per-cycle compare, strobe protocol on both instances, strobe widths on the 2/3/2 one
  logic       a_prev_we_n = 1'b1, b_prev_we_n = 1'b1;
  logic [7:0] a_prev_ad = 8'h0, b_prev_ad = 8'h0;
  int         b_cs_cnt = 0, b_we_cnt = 0, b_strobes = 0;

  initial forever begin
    @(negedge clk);
    chk("ready",     int'(a_req_ready), int'(m_started && m_idle()));
    chk("cs_n",      int'(a_cs_n),
        int'(!(m_active && m_age < (m_we ? S + P + H : S + P))));
    chk("we_n",      int'(a_we_n), int'(!(m_active && m_we && m_age >= S && m_age < S + P)));
    chk("rsp_valid", int'(a_rsp_valid), int'(m_active && !m_we && m_age == S + P + 1));
    chk("rsp_rdata", int'(a_rsp_rdata), int'(e_rdata));
    chk("mem_a",     int'(a_mem_a), int'(e_a));
    chk("mem_d",     int'(a_mem_d), int'(e_d));

    chk("a_we_needs_cs", int'(!a_we_n && a_cs_n), 0);
    chk("b_we_needs_cs", int'(!b_we_n && b_cs_n), 0);
    if (!a_we_n && !a_prev_we_n) chk("a_stable_in_pulse", int'({a_mem_a, a_mem_d}), int'(a_prev_ad));
    if (!b_we_n && !b_prev_we_n) chk("b_stable_in_pulse", int'({b_mem_a, b_mem_d}), int'(b_prev_ad));
    a_prev_we_n = a_we_n;
    b_prev_we_n = b_we_n;
    a_prev_ad   = {a_mem_a, a_mem_d};
    b_prev_ad   = {b_mem_a, b_mem_d};

    if (!rst_n) begin
      b_cs_cnt = 0;
      b_we_cnt = 0;
    end else if (!b_cs_n) begin
      if (!b_we_n && b_we_cnt == 0) chk("b_setup_width", b_cs_cnt, S2);
      b_cs_cnt++;
      if (!b_we_n) b_we_cnt++;
    end else if (b_cs_cnt != 0) begin
      b_strobes++;
      if (b_we_cnt != 0) begin
        chk("b_pulse_width", b_we_cnt, P2);
        chk("b_write_cs_width", b_cs_cnt, S2 + P2 + H2);
      end else begin
        chk("b_read_cs_width", b_cs_cnt, S2 + P2);
      end
      b_cs_cnt = 0;
      b_we_cnt = 0;
    end
  end

  int issued_a = 0;
  int last_acc = 0;

  // Called at posedge+1; returns at acceptance edge+1 with req_valid dropped
  task automatic issue(input bit sel, input bit we, input logic [3:0] addr, input logic [3:0] data);
    int n;
    if (sel) begin
      b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr; b_req_wdata = data;
    end else begin
      a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_wdata = data;
    end
    n = 0;
    forever begin
      @(negedge clk);
      if (sel ? b_req_ready : a_req_ready) break;
      n++;
      if (n > 40) break;
    end
    if (n > 40) chk("accept_timeout", n, 0);
    @(posedge clk);
    #1;
    last_acc = cyc;
    if (sel) b_req_valid = 1'b0;
    else begin
      a_req_valid = 1'b0;
      issued_a++;
    end
  endtask

  task automatic read_chk(input bit sel, input logic [3:0] addr, input logic [3:0] exp, input int lat);
    int n;
    issue(sel, 1'b0, addr, 4'($urandom_range(0, 15)));
    n = 0;
    forever begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (sel ? b_rsp_valid : a_rsp_valid) break;
      if (n > 20) break;
    end
    chk(sel ? "b_read_latency" : "a_read_latency", n, lat);
    chk(sel ? "b_read_data" : "a_read_data", int'(sel ? b_rsp_rdata : a_rsp_rdata), int'(exp));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t1, t2, gap;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", int'(a_req_ready), 0);
    chk("reset_cs_n",  int'(a_cs_n), 1);
    chk("reset_we_n",  int'(a_we_n), 1);
    chk("reset_mem_a", int'(a_mem_a), 0);
    chk("reset_rdata", int'(a_rsp_rdata), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_reset", int'(a_req_ready), 1);

    issue(0, 1'b1, 4'd3, 4'hA);
    read_chk(0, 4'd3, 4'hA, 4);
    chk("ram_pin_addr3", int'(a_ram[4'b0011]), 'hA);
    issue(0, 1'b1, 4'd0, 4'h1);
    issue(0, 1'b1, 4'd15, 4'hF);
    read_chk(0, 4'd0, 4'h1, 4);
    read_chk(0, 4'd15, 4'hF, 4);
    issue(0, 1'b1, 4'd1, 4'h6);
    read_chk(0, 4'd1, 4'h6, 4);
    chk("ram_pin_addr1", int'(a_ram[4'b0001]), 'h6);

    issue(0, 1'b1, 4'd5, 4'h7);
    t1 = last_acc;
    issue(0, 1'b1, 4'd6, 4'h8);
    t2 = last_acc;
    chk("b2b_write_spacing", t2 - t1, S + P + H + 1);
    issue(0, 1'b1, 4'd7, 4'h9);
    read_chk(0, 4'd6, 4'h8, 4);

    issue(0, 1'b1, 4'd9, 4'hC);
    @(posedge clk);
    #1;
    chk("abort_in_pulse", int'(a_we_n), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_we_n", int'(a_we_n), 1);
    chk("abort_cs_n", int'(a_cs_n), 1);
    chk("abort_rsp",  int'(a_rsp_valid), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_abort", int'(a_req_ready), 1);
    read_chk(0, 4'd9, init_val(9), 4);

    for (int i = 0; i < 500; i++) begin
      issue(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      gap = $urandom_range(0, 2);
      if (gap != 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    repeat (10) @(posedge clk);
    #1;
    chk("accept_count", n_acc, issued_a);

    issue(1, 1'b1, 4'd5, 4'h9);
    read_chk(1, 4'd5, 4'h9, S2 + P2 + 1);
    issue(1, 1'b1, 4'd0, 4'h3);
    read_chk(1, 4'd0, 4'h3, S2 + P2 + 1);
    repeat (3) @(posedge clk);
    #1;
    chk("b_strobe_count", b_strobes, 4);
    chk("b_ram_addr5", int'(b_ram[4'b0101]), 'h9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter SETUP_CYC, default 1: cycles of address/CS setup before the write strobe; legal range 1..7.
REQ-002 Parameter PULSE_CYC, default 2: cycles of the WE strobe on writes, or of the read access window on reads; legal range 1..7.
REQ-003 Parameter HOLD_CYC, default 1: cycles of address/data hold after the write strobe; legal range 1..7.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  controller can accept a request.
REQ-008 req_we  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  4  word address, 0..15.
REQ-010 req_wdata  input  4  write data.
REQ-011 rsp_valid  output  1  one-cycle read-data strobe.
REQ-012 rsp_rdata  output  4  read data; valid when rsp_valid = 1.
REQ-013 mem_a  output  4  to the 16x4 memory; mem_a[3] drives A0 (MSB) down to mem_a[0], which drives A3.
REQ-014 mem_d  output  4  to D0..D3; mem_d[0] drives D0.
REQ-015 mem_q  input  4  from O0..O3; mem_q[0] comes from O0.
REQ-016 mem_cs_n  output  1  chip select, active-low.
REQ-017 mem_we_n  output  1  write enable, active-low.

Function
REQ-018 The FSM states SHALL be IDLE, SETUP, PULSE, HOLD and RESP, with one cycle counter shared across states.
REQ-019 req_ready SHALL be 1 only in IDLE; a request is accepted on the edge where req_valid = 1 and req_ready = 1.
REQ-020 On acceptance, the controller SHALL register addr/we/wdata, drive them onto mem_a/mem_d, and move to SETUP.
REQ-021 SETUP: mem_cs_n = 0, mem_we_n = 1, for SETUP_CYC cycles, then PULSE.
REQ-022 PULSE, write: mem_cs_n = 0, mem_we_n = 0, for PULSE_CYC cycles, then HOLD.
REQ-023 PULSE, read: mem_cs_n = 0, mem_we_n = 1, for PULSE_CYC cycles; mem_q SHALL be sampled on the last PULSE edge; next state is RESP.
REQ-024 HOLD: mem_cs_n = 0, mem_we_n = 1, mem_a/mem_d unchanged, for HOLD_CYC cycles, then IDLE.
REQ-025 RESP: rsp_valid = 1 for exactly one cycle with the sampled data, mem_cs_n = 1, then IDLE.
REQ-026 mem_we_n SHALL never be 0 while mem_cs_n = 1; mem_a and mem_d SHALL NOT change while mem_we_n = 0.
REQ-027 Write occupancy SHALL be SETUP_CYC+PULSE_CYC+HOLD_CYC cycles from acceptance to IDLE.
REQ-028 For a read, rsp_valid SHALL rise SETUP_CYC+PULSE_CYC+1 edges after the acceptance edge.
REQ-029 In IDLE, mem_cs_n = 1, mem_we_n = 1, and mem_a/mem_d SHALL hold their last values.
REQ-030 Back-to-back requests: the earliest next acceptance is the first IDLE cycle, so there is one idle gap between transactions.
REQ-031 req_valid while busy SHALL be ignored, not queued; the requester holds it until accepted.
REQ-032 Addresses 0 and 15 are valid, with no wrap logic; mem_q content is otherwise unchecked.
REQ-033 rsp_rdata SHALL hold its value between responses.

Reset
REQ-034 While rst_n = 0: state = IDLE, counter = 0, mem_cs_n = 1, mem_we_n = 1, mem_a = 0, mem_d = 0, rsp_valid = 0, rsp_rdata = 0, req_ready = 0.
REQ-035 Reset mid-transaction SHALL deassert mem_we_n and mem_cs_n immediately (asynchronously); the aborted operation produces no response.
REQ-036 req_ready SHALL rise on the first clock edge after rst_n deasserts.

Structure
REQ-037 Package mem_ctrl_pkg SHALL hold the state enum, ADDR_W = 4, DATA_W = 4 and the counter width (3 bits).
REQ-038 Single module, no sub-modules; the memory model is instantiated only in the testbench.

Verification
REQ-039 Reset, then write 4'hA to address 3, read address 3 -> rsp_valid one cycle with rsp_rdata = 4'hA, read latency 4 cycles at default parameters.
REQ-040 Write address 0 = 4'h1 and address 15 = 4'hF, read both back -> 4'h1 and 4'hF; the mem_a bit order is checked against the memory's A0..A3.
REQ-041 Hold req_valid during a write -> exactly one acceptance per IDLE, gap of 1 cycle, no dropped or duplicated transaction.
REQ-042 Assert rst_n = 0 during PULSE of a write -> mem_we_n = 1 and mem_cs_n = 1 in the same cycle, no rsp_valid, req_ready = 1 one edge after release.
REQ-043 Run SETUP_CYC = 2, PULSE_CYC = 3, HOLD_CYC = 2 -> strobe widths are exactly 2/3/2 cycles; a protocol assertion on REQ-026 holds throughout.
REQ-044 Random writes and reads over 16 addresses, 500 transactions -> scoreboard matches every response.
